hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage core; replaces the ad-hoc bubbler/forwarder pair.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller and the EX operand mux.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic ex_hold;
    logic ex_mem_bubble;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam ctrl_t CTRL_MC = '{pc_stall: 1'b1, if_id_stall: 1'b1, ex_hold: 1'b1,
                                ex_mem_bubble: 1'b1, default: 1'b0};

  localparam ctrl_t CTRL_LOAD_USE = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                      id_ex_bubble: 1'b1, default: 1'b0};

  localparam ctrl_t CTRL_FLUSH = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller: load-use bubbles, EX forwarding, branch flush,
// multi-cycle EX stalls and saturating stall/flush statistics.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mc_start,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             clr_stats,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             ex_mem_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The first EX cycle and the final MC_WAIT cycle are both stalls, so the
  // counter only has to cover MC_LAT-3 extra cycles.
  localparam bit          MC_STALLS = (MC_LAT >= 2);
  localparam bit          MC_WAITS  = (MC_LAT >= 3);
  localparam int unsigned MC_INIT   = MC_WAITS ? (MC_LAT - 3) : 0;
  localparam int unsigned CW        = (MC_INIT > 0) ? $clog2(MC_INIT + 1) : 1;

  state_t        state;
  logic [CW-1:0] mc_cnt;
  ctrl_t         ctrl;
  logic          load_use;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) return FWD_MEM;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == src))    return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs);
    fwd_b = fwd_sel(ex_rt);
  end

  assign load_use = id_valid && ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (state)
      RUN: begin
        if (ex_branch_taken)              ctrl = CTRL_FLUSH;
        else if (ex_mc_start && MC_STALLS) ctrl = CTRL_MC;
        else if (load_use)                ctrl = CTRL_LOAD_USE;
      end
      MC_WAIT: ctrl = CTRL_MC;
      default: ctrl = CTRL_NOP;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!ex_branch_taken && ex_mc_start && MC_WAITS) begin
            state  <= MC_WAIT;
            mc_cnt <= CW'(MC_INIT);
          end
        end
        MC_WAIT: begin
          if (mc_cnt == '0) state <= RUN;
          else              mc_cnt <= mc_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign pc_stall      = ctrl.pc_stall;
  assign if_id_stall   = ctrl.if_id_stall;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_hold       = ctrl.ex_hold;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mc_busy       = (state == MC_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ctrl.pc_stall),
    .clr   (clr_stats),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ctrl.if_id_flush),
    .clr   (clr_stats),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (MC_LAT=4/CNT_W=16 and MC_LAT=1/CNT_W=2)
// share one input stream and are compared against a cycle-count reference model.
module tb_hazard_unit;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_mc_start;
    logic       ex_branch_taken;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_reg_write;
    logic       wb_reg_write;
    logic       clr_stats;
  } in_t;

  typedef struct packed {
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        ex_hold;
    logic        ex_mem_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mc_busy;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    int   cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  in_t  cur   = '0;

  obs_t act_a, act_b;
  logic [1:0] sc_b, fc_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  bit   done   = 0;

  int lat[2]  = '{4, 1};
  int maxc[2] = '{65535, 3};
  int left[2] = '{0, 0};
  int scnt[2] = '{0, 0};
  int fcnt[2] = '{0, 0};

  always #5 clock = ~clock;

  hazard_unit #(.REG_W(5), .MC_LAT(4), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset),
    .id_valid(cur.id_valid), .id_rs(cur.id_rs), .id_rt(cur.id_rt), .id_uses_rt(cur.id_uses_rt),
    .ex_rs(cur.ex_rs), .ex_rt(cur.ex_rt), .ex_rd(cur.ex_rd),
    .ex_reg_write(cur.ex_reg_write), .ex_mem_read(cur.ex_mem_read),
    .ex_mc_start(cur.ex_mc_start), .ex_branch_taken(cur.ex_branch_taken),
    .mem_rd(cur.mem_rd), .wb_rd(cur.wb_rd),
    .mem_reg_write(cur.mem_reg_write), .wb_reg_write(cur.wb_reg_write),
    .clr_stats(cur.clr_stats),
    .pc_stall(act_a.pc_stall), .if_id_stall(act_a.if_id_stall),
    .id_ex_bubble(act_a.id_ex_bubble), .ex_hold(act_a.ex_hold),
    .ex_mem_bubble(act_a.ex_mem_bubble), .if_id_flush(act_a.if_id_flush),
    .id_ex_flush(act_a.id_ex_flush), .fwd_a(act_a.fwd_a), .fwd_b(act_a.fwd_b),
    .mc_busy(act_a.mc_busy), .stall_cnt(act_a.stall_cnt), .flush_cnt(act_a.flush_cnt)
  );

  hazard_unit #(.REG_W(5), .MC_LAT(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset),
    .id_valid(cur.id_valid), .id_rs(cur.id_rs), .id_rt(cur.id_rt), .id_uses_rt(cur.id_uses_rt),
    .ex_rs(cur.ex_rs), .ex_rt(cur.ex_rt), .ex_rd(cur.ex_rd),
    .ex_reg_write(cur.ex_reg_write), .ex_mem_read(cur.ex_mem_read),
    .ex_mc_start(cur.ex_mc_start), .ex_branch_taken(cur.ex_branch_taken),
    .mem_rd(cur.mem_rd), .wb_rd(cur.wb_rd),
    .mem_reg_write(cur.mem_reg_write), .wb_reg_write(cur.wb_reg_write),
    .clr_stats(cur.clr_stats),
    .pc_stall(act_b.pc_stall), .if_id_stall(act_b.if_id_stall),
    .id_ex_bubble(act_b.id_ex_bubble), .ex_hold(act_b.ex_hold),
    .ex_mem_bubble(act_b.ex_mem_bubble), .if_id_flush(act_b.if_id_flush),
    .id_ex_flush(act_b.id_ex_flush), .fwd_a(act_b.fwd_a), .fwd_b(act_b.fwd_b),
    .mc_busy(act_b.mc_busy), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  assign act_b.stall_cnt = {14'd0, sc_b};
  assign act_b.flush_cnt = {14'd0, fc_b};

  // Reference: "left" is how many more cycles the multi-cycle op keeps the
  // pipeline frozen after the current one.
  function automatic logic [1:0] pick(in_t i, logic [4:0] src);
    if (i.mem_reg_write && i.mem_rd != 0 && i.mem_rd == src) return 2'd1;
    if (i.wb_reg_write && i.wb_rd != 0 && i.wb_rd == src)    return 2'd2;
    return 2'd0;
  endfunction

  function automatic obs_t model_out(in_t i, int l, int lf, int sc, int fc);
    obs_t o = '0;
    bit lu = i.id_valid && i.ex_mem_read && i.ex_reg_write && i.ex_rd != 0 &&
             (i.ex_rd == i.id_rs || (i.id_uses_rt && i.ex_rd == i.id_rt));
    o.fwd_a = pick(i, i.ex_rs);
    o.fwd_b = pick(i, i.ex_rt);
    o.stall_cnt = 16'(sc);
    o.flush_cnt = 16'(fc);
    if (lf > 0) begin
      o.mc_busy = 1; o.pc_stall = 1; o.if_id_stall = 1; o.ex_hold = 1; o.ex_mem_bubble = 1;
    end else if (i.ex_branch_taken) begin
      o.if_id_flush = 1; o.id_ex_flush = 1;
    end else if (i.ex_mc_start && l >= 2) begin
      o.pc_stall = 1; o.if_id_stall = 1; o.ex_hold = 1; o.ex_mem_bubble = 1;
    end else if (lu) begin
      o.pc_stall = 1; o.if_id_stall = 1; o.id_ex_bubble = 1;
    end
    return o;
  endfunction

  task automatic drive(in_t i, logic rst);
    exp_t e;
    obs_t o;
    @(negedge clock);
    cur   = i;
    reset = rst;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
      o = model_out(i, lat[k], left[k], scnt[k], fcnt[k]);
      if (k == 0) e.a = o; else e.b = o;
      if (rst) begin
        if (i.clr_stats) begin
          scnt[k] = 0; fcnt[k] = 0;
        end else begin
          if (o.pc_stall && scnt[k] < maxc[k])    scnt[k]++;
          if (o.if_id_flush && fcnt[k] < maxc[k]) fcnt[k]++;
        end
        if (left[k] > 0)                                            left[k]--;
        else if (!i.ex_branch_taken && i.ex_mc_start && lat[k] >= 2) left[k] = lat[k] - 2;
      end
    end
    e.cyc = ncyc;
    sb.push_back(e);
    ncyc++;
  endtask

  function automatic in_t rand_in();
    in_t r;
    r.id_valid        = 1'($urandom_range(0, 3) != 0);
    r.id_rs           = 5'($urandom_range(0, 3));
    r.id_rt           = 5'($urandom_range(0, 3));
    r.id_uses_rt      = 1'($urandom_range(0, 1));
    r.ex_rs           = 5'($urandom_range(0, 3));
    r.ex_rt           = 5'($urandom_range(0, 3));
    r.ex_rd           = 5'($urandom_range(0, 3));
    r.ex_reg_write    = 1'($urandom_range(0, 1));
    r.ex_mem_read     = 1'($urandom_range(0, 1));
    r.ex_mc_start     = 1'($urandom_range(0, 9) == 0);
    r.ex_branch_taken = 1'($urandom_range(0, 9) == 0);
    r.mem_rd          = 5'($urandom_range(0, 3));
    r.wb_rd           = 5'($urandom_range(0, 3));
    r.mem_reg_write   = 1'($urandom_range(0, 1));
    r.wb_reg_write    = 1'($urandom_range(0, 1));
    r.clr_stats       = 1'($urandom_range(0, 63) == 0);
    return r;
  endfunction

  // Monitor: every cycle the DUT presents a fresh output vector shortly after the drive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (act_a !== e.a) begin
          errors++;
          $display("FAIL lat4 cyc=%0d act=%h exp=%h", e.cyc, act_a, e.a);
        end
        checks++;
        if (act_b !== e.b) begin
          errors++;
          $display("FAIL lat1 cyc=%0d act=%h exp=%h", e.cyc, act_b, e.b);
        end
      end
    end
  end

  initial begin
    in_t idle, t, lu;
    idle = '0;

    // Reset held with random inputs, then released onto idle inputs.
    for (int n = 0; n < 4; n++) drive(rand_in(), 1'b0);
    drive(idle, 1'b1);
    drive(idle, 1'b1);

    // Load-use on rs, then the same with ex_rd=0.
    lu = idle;
    lu.id_valid = 1; lu.ex_mem_read = 1; lu.ex_reg_write = 1; lu.ex_rd = 5; lu.id_rs = 5;
    drive(lu, 1'b1);
    drive(idle, 1'b1);
    t = lu; t.ex_rd = 0; t.id_rs = 0;
    drive(t, 1'b1);
    t = lu; t.id_rs = 2; t.id_rt = 5; t.id_uses_rt = 1;
    drive(t, 1'b1);
    t.id_uses_rt = 0;
    drive(t, 1'b1);

    // Forwarding priority.
    t = idle; t.ex_rs = 3; t.mem_rd = 3; t.wb_rd = 3; t.mem_reg_write = 1; t.wb_reg_write = 1;
    drive(t, 1'b1);
    t.mem_reg_write = 0;
    drive(t, 1'b1);
    t.ex_rt = 0; t.mem_rd = 0; t.wb_rd = 0; t.mem_reg_write = 1;
    drive(t, 1'b1);

    // Multi-cycle op, then a branch and an mc_start arriving during MC_WAIT.
    t = idle; t.ex_mc_start = 1;
    drive(t, 1'b1);
    for (int n = 0; n < 4; n++) drive(idle, 1'b1);
    drive(t, 1'b1);
    t = idle; t.ex_branch_taken = 1; t.ex_mc_start = 1;
    drive(t, 1'b1);
    drive(t, 1'b1);
    drive(idle, 1'b1);

    // Branch together with a load-use condition.
    t = lu; t.ex_branch_taken = 1;
    drive(t, 1'b1);
    drive(idle, 1'b1);

    // Saturate the 2-bit counters of the second instance, then clear.
    for (int n = 0; n < 6; n++) drive(lu, 1'b1);
    t = lu; t.clr_stats = 1;
    drive(t, 1'b1);
    drive(idle, 1'b1);

    // Reset asserted in the middle of MC_WAIT.
    t = idle; t.ex_mc_start = 1;
    drive(t, 1'b1);
    drive(idle, 1'b1);
    drive(idle, 1'b0);
    drive(idle, 1'b1);

    for (int n = 0; n < 3000; n++) drive(rand_in(), (($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1));

    drive(idle, 1'b1);
    @(negedge clock);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout act=running required=finished");
      $fatal(1);
    end
  end

endmodule
